// File: rtl/knn_stream_classifier_pkg.sv
// Shared types and defaults for the streaming k-nearest-neighbour classifier.
package knn_stream_classifier_pkg;

    localparam int DEF_COORD_W = 16;
    localparam int DEF_N_DIM   = 2;
    localparam int DEF_K       = 4;
    localparam int DEF_LABEL_W = 8;

    // Controller states: RUN accepts points, DRAIN waits for the pipeline,
    // VOTE is a single cycle, DONE holds the result.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_VOTE  = 3'd3,
        S_DONE  = 3'd4
    } knn_state_t;

    // Width that holds a sum of n_dim squares of coord_w-bit differences
    // without overflow; one spare bit keeps every real distance below the
    // all-ones value used to mark an empty slot.
    function automatic int dist_width(input int coord_w, input int n_dim);
        return 2 * coord_w + $clog2(n_dim) + 1;
    endfunction

endpackage

// File: rtl/knn_stream_classifier_dist.sv
// Squared Euclidean distance between the latched query and a training point,
// registered once. A tag (label and last flag) travels alongside the distance.
module knn_stream_classifier_dist
    import knn_stream_classifier_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int N_DIM   = DEF_N_DIM,
    parameter int DIST_W  = dist_width(DEF_COORD_W, DEF_N_DIM),
    parameter int TAG_W   = DEF_LABEL_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [N_DIM*COORD_W-1:0] query_p0,
    input  logic [N_DIM*COORD_W-1:0] point_p0,
    input  logic [TAG_W-1:0]         tag_p0,
    input  logic                     vld_p0,
    output logic [DIST_W-1:0]        dist_p1,
    output logic [TAG_W-1:0]         tag_p1,
    output logic                     vld_p1
);

    logic [COORD_W-1:0]   q;
    logic [COORD_W-1:0]   p;
    logic [COORD_W-1:0]   diff;
    logic [2*COORD_W-1:0] sq;
    logic [DIST_W-1:0]    sum;

    // Absolute difference per dimension, squared, accumulated at full width.
    always_comb begin
        sum  = '0;
        q    = '0;
        p    = '0;
        diff = '0;
        sq   = '0;
        for (int d = 0; d < N_DIM; d++) begin
            q    = query_p0[d*COORD_W +: COORD_W];
            p    = point_p0[d*COORD_W +: COORD_W];
            diff = (q > p) ? (q - p) : (p - q);
            sq   = {{COORD_W{1'b0}}, diff} * {{COORD_W{1'b0}}, diff};
            sum  = sum + {{(DIST_W-2*COORD_W){1'b0}}, sq};
        end
    end

    // S1 boundary: distance and tag data, no reset needed on data.
    always_ff @(posedge clk) begin
        dist_p1 <= sum;
        tag_p1  <= tag_p0;
    end

    // S1 valid; a flush drops whatever is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_p1 <= 1'b0;
        else      vld_p1 <= vld_p0 && !flush;
    end

endmodule

// File: rtl/knn_stream_classifier.sv
// Streaming k-NN classifier: latches a query, streams labelled points through
// a distance stage, keeps a sorted list of the K nearest, then votes.
module knn_stream_classifier
    import knn_stream_classifier_pkg::*;
#(
    parameter int  COORD_W = DEF_COORD_W,
    parameter int  N_DIM   = DEF_N_DIM,
    parameter int  K       = DEF_K,
    parameter int  LABEL_W = DEF_LABEL_W,
    localparam int DIST_W  = dist_width(COORD_W, N_DIM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_DIM*COORD_W-1:0]  query,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_DIM*COORD_W-1:0]  point,
    input  logic [LABEL_W-1:0]        label,
    input  logic                      last,
    output logic [K*DIST_W-1:0]       nb_dist,
    output logic [K*LABEL_W-1:0]      nb_label,
    output logic [$clog2(K+1)-1:0]    nb_count,
    output logic [LABEL_W-1:0]        class_label,
    output logic                      done,
    output logic                      busy
);

    localparam int CNT_W = $clog2(K+1);
    localparam int TAG_W = LABEL_W + 1;

    knn_state_t                 state;
    logic                       accept;
    logic [N_DIM*COORD_W-1:0]   query_p0;
    logic [N_DIM*COORD_W-1:0]   point_p0;
    logic [TAG_W-1:0]           tag_p0;
    logic                       vld_p0;
    logic [DIST_W-1:0]          dist_p1;
    logic [TAG_W-1:0]           tag_p1;
    logic                       vld_p1;
    logic [LABEL_W-1:0]         label_p1;
    logic                       last_p1;

    logic [DIST_W-1:0]          lst_dist  [K];
    logic [LABEL_W-1:0]         lst_label [K];
    logic [DIST_W-1:0]          nxt_dist  [K];
    logic [LABEL_W-1:0]         nxt_label [K];
    logic [K-1:0]               gt;
    logic [K-1:0]               slot_vld;
    logic [CNT_W-1:0]           votes [K];
    logic [CNT_W-1:0]           best_cnt;
    logic [LABEL_W-1:0]         vote_label;

    // start wins over a simultaneous point so an aborted run leaves nothing behind
    assign accept = in_valid && in_ready && !start;
    assign {last_p1, label_p1} = tag_p1;

    // P0 boundary: capture the point every cycle; the query only on start.
    always_ff @(posedge clk) begin
        point_p0 <= point;
        tag_p0   <= {last, label};
        if (start) query_p0 <= query;
    end

    // P0 valid marks a point accepted on the previous edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_p0 <= 1'b0;
        else      vld_p0 <= accept;
    end

    knn_stream_classifier_dist #(
        .COORD_W (COORD_W),
        .N_DIM   (N_DIM),
        .DIST_W  (DIST_W),
        .TAG_W   (TAG_W)
    ) u_dist (
        .clk      (clk),
        .rst      (rst),
        .flush    (start),
        .query_p0 (query_p0),
        .point_p0 (point_p0),
        .tag_p0   (tag_p0),
        .vld_p0   (vld_p0),
        .dist_p1  (dist_p1),
        .tag_p1   (tag_p1),
        .vld_p1   (vld_p1)
    );

    // Sorted insertion: gt is a thermometer since the list is ascending and
    // empty slots hold all-ones, which no real distance can reach.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            gt[i]        = lst_dist[i] > dist_p1;
            nxt_dist[i]  = lst_dist[i];
            nxt_label[i] = lst_label[i];
        end
        if (gt[0]) begin
            nxt_dist[0]  = dist_p1;
            nxt_label[0] = label_p1;
        end
        for (int i = 1; i < K; i++) begin
            if (gt[i] && !gt[i-1]) begin
                nxt_dist[i]  = dist_p1;
                nxt_label[i] = label_p1;
            end else if (gt[i]) begin
                nxt_dist[i]  = lst_dist[i-1];
                nxt_label[i] = lst_label[i-1];
            end
        end
    end

    // S2 boundary: neighbour list and occupancy, cleared by reset and start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < K; i++) begin
                lst_dist[i]  <= '1;
                lst_label[i] <= '0;
            end
            nb_count <= '0;
        end else if (start) begin
            for (int i = 0; i < K; i++) begin
                lst_dist[i]  <= '1;
                lst_label[i] <= '0;
            end
            nb_count <= '0;
        end else if (vld_p1 && gt[K-1]) begin
            lst_dist  <= nxt_dist;
            lst_label <= nxt_label;
            if (nb_count != CNT_W'(K)) nb_count <= nb_count + 1'b1;
        end
    end

    // Majority vote over occupied slots; strict compare lets the nearest win ties.
    always_comb begin
        best_cnt   = '0;
        vote_label = '0;
        for (int i = 0; i < K; i++) begin
            slot_vld[i] = lst_dist[i] != '1;
        end
        for (int i = 0; i < K; i++) begin
            votes[i] = '0;
            for (int j = 0; j < K; j++) begin
                if (slot_vld[i] && slot_vld[j] && lst_label[j] == lst_label[i])
                    votes[i] = votes[i] + 1'b1;
            end
        end
        for (int i = 0; i < K; i++) begin
            if (slot_vld[i] && votes[i] > best_cnt) begin
                best_cnt   = votes[i];
                vote_label = lst_label[i];
            end
        end
    end

    // Controller with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            class_label <= '0;
        end else if (start) begin
            state    <= S_RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (accept && last) begin
                        state    <= S_DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (vld_p1 && last_p1) state <= S_VOTE;
                end
                S_VOTE: begin
                    class_label <= vote_label;
                    state       <= S_DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_pack
        assign nb_dist[g*DIST_W +: DIST_W]    = lst_dist[g];
        assign nb_label[g*LABEL_W +: LABEL_W] = lst_label[g];
    end

endmodule
